// File: rtl/siso_tx_scheduler_if.sv
// Request-side bus of the SISO transmit scheduler.
// The requesters (master) present words with valid flags. The scheduler
// (slave) answers with a per-requester ready.
interface siso_tx_scheduler_if #(
    parameter int DATA_WIDTH = 8
);
    logic [1:0]            Req_Valid_In;
    logic [DATA_WIDTH-1:0] Req_Data0_In;
    logic [DATA_WIDTH-1:0] Req_Data1_In;
    logic [1:0]            Req_Ready_Out;

    modport master (
        output Req_Valid_In,
        output Req_Data0_In,
        output Req_Data1_In,
        input  Req_Ready_Out
    );

    modport slave (
        input  Req_Valid_In,
        input  Req_Data0_In,
        input  Req_Data1_In,
        output Req_Ready_Out
    );
endinterface

// File: rtl/siso_tx_scheduler.sv
// Round-robin scheduler that serialises one word per frame onto a shared
// SISO chain. A frame is a start bit (0), the data LSB first, and a stop bit (1).
// The frame is followed by IDLE_GAP idle clocks. All line-side outputs are
// registered on the rising edge, so a negedge-clocked SISO samples stable bits.
module siso_tx_scheduler #(
    parameter int DATA_WIDTH = 8,
    parameter int IDLE_GAP   = 2
) (
    input  logic                  Clk_In,
    input  logic                  Reset_In,
    siso_tx_scheduler_if.slave    req_if,
    output logic [1:0]            Grant_Out,
    output logic                  Serial_Data_Out,
    output logic                  Frame_Active_Out,
    output logic [5:0]            Bit_Count_Out
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_GAP
    } state_t;

    localparam logic [5:0] BIT_LAST = 6'(DATA_WIDTH - 1);
    localparam logic [3:0] GAP_LAST = 4'(IDLE_GAP - 1);

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_hold;        // shifts right as bits go out
    logic                  r_last_grant;  // 1 => requester 1 owned the last frame
    logic [1:0]            r_grant;
    logic                  r_serial;
    logic                  r_frame_active;
    logic [5:0]            r_bit_count;
    logic [3:0]            r_gap_count;

    logic                  w_sel;
    logic [1:0]            w_ready;
    logic [DATA_WIDTH-1:0] w_sel_data;

    // Arbitration: a lone requester wins. On a tie, the one that did not own the last frame wins.
    always_comb begin
        w_sel = 1'b0;
        case (req_if.Req_Valid_In)
            2'b01:   w_sel = 1'b0;
            2'b10:   w_sel = 1'b1;
            2'b11:   w_sel = ~r_last_grant;
            default: w_sel = 1'b0;
        endcase
        w_ready = 2'b00;
        if ((r_state == S_IDLE) && !Reset_In && (|req_if.Req_Valid_In)) begin
            w_ready = w_sel ? 2'b10 : 2'b01;
        end
        w_sel_data = w_sel ? req_if.Req_Data1_In : req_if.Req_Data0_In;
    end

    assign req_if.Req_Ready_Out = w_ready;
    assign Grant_Out            = r_grant;
    assign Serial_Data_Out      = r_serial;
    assign Frame_Active_Out     = r_frame_active;
    assign Bit_Count_Out        = r_bit_count;

    // Frame sequencer. Each output takes the value it must show in the state being entered.
    always_ff @(posedge Clk_In or posedge Reset_In) begin
        if (Reset_In) begin
            r_state        <= S_IDLE;
            r_hold         <= '0;
            r_last_grant   <= 1'b1;
            r_grant        <= 2'b00;
            r_serial       <= 1'b1;
            r_frame_active <= 1'b0;
            r_bit_count    <= 6'd0;
            r_gap_count    <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (|w_ready) begin
                        r_hold         <= w_sel_data;
                        r_last_grant   <= w_sel;
                        r_grant        <= w_ready;
                        r_serial       <= 1'b0;
                        r_frame_active <= 1'b1;
                        r_state        <= S_START;
                    end
                end
                S_START: begin
                    r_serial    <= r_hold[0];
                    r_hold      <= r_hold >> 1;
                    r_bit_count <= 6'd0;
                    r_state     <= S_DATA;
                end
                S_DATA: begin
                    if (r_bit_count == BIT_LAST) begin
                        r_serial    <= 1'b1;
                        r_bit_count <= 6'd0;
                        r_state     <= S_STOP;
                    end else begin
                        r_serial    <= r_hold[0];
                        r_hold      <= r_hold >> 1;
                        r_bit_count <= r_bit_count + 6'd1;
                    end
                end
                S_STOP: begin
                    r_serial       <= 1'b1;
                    r_frame_active <= 1'b0;
                    r_grant        <= 2'b00;
                    r_gap_count    <= 4'd0;
                    if (IDLE_GAP > 0) begin
                        r_state <= S_GAP;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_GAP: begin
                    if (r_gap_count == GAP_LAST) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_gap_count <= r_gap_count + 4'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_siso_tx_scheduler.sv
// Directed bench for siso_tx_scheduler. It checks the default 8-bit / gap-2 instance
// and also a 5-bit / gap-0 instance.
module tb_siso_tx_scheduler;

    logic clk = 1'b0;
    logic Reset_In = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    siso_tx_scheduler_if #(.DATA_WIDTH(8)) bus8 ();
    siso_tx_scheduler_if #(.DATA_WIDTH(5)) bus5 ();

    logic [1:0] a_grant, b_grant;
    logic       a_ser, b_ser, a_fa, b_fa;
    logic [5:0] a_bc, b_bc;

    siso_tx_scheduler #(.DATA_WIDTH(8), .IDLE_GAP(2)) dut_a (
        .Clk_In(clk), .Reset_In(Reset_In), .req_if(bus8.slave),
        .Grant_Out(a_grant), .Serial_Data_Out(a_ser),
        .Frame_Active_Out(a_fa), .Bit_Count_Out(a_bc)
    );

    siso_tx_scheduler #(.DATA_WIDTH(5), .IDLE_GAP(0)) dut_b (
        .Clk_In(clk), .Reset_In(Reset_In), .req_if(bus5.slave),
        .Grant_Out(b_grant), .Serial_Data_Out(b_ser),
        .Frame_Active_Out(b_fa), .Bit_Count_Out(b_bc)
    );

    task automatic do_reset();
        Reset_In = 1'b1;
        bus8.Req_Valid_In = 2'b00;
        bus5.Req_Valid_In = 2'b00;
        repeat (2) @(negedge clk);
        Reset_In = 1'b0;
    endtask

    task automatic test_reset();
        Reset_In = 1'b1;
        bus8.Req_Valid_In = 2'b11;
        bus8.Req_Data0_In = 8'h01;
        bus8.Req_Data1_In = 8'h02;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (a_ser !== 1'b1) begin errors++; $display("FAIL reset_line got %b exp 1", a_ser); end
        checks++; if (a_fa !== 1'b0) begin errors++; $display("FAIL reset_active got %b exp 0", a_fa); end
        checks++; if (a_grant !== 2'b00) begin errors++; $display("FAIL reset_grant got %b exp 00", a_grant); end
        checks++; if (a_bc !== 6'd0) begin errors++; $display("FAIL reset_bitcount got %0d exp 0", a_bc); end
        checks++; if (bus8.Req_Ready_Out !== 2'b00) begin errors++; $display("FAIL reset_ready got %b exp 00", bus8.Req_Ready_Out); end
        @(negedge clk);
        Reset_In = 1'b0;
        #1;
        checks++; if (bus8.Req_Ready_Out !== 2'b01) begin errors++; $display("FAIL release_ready got %b exp 01", bus8.Req_Ready_Out); end
        bus8.Req_Valid_In = 2'b00;
        $display("test_reset done");
    endtask

    task automatic test_single_frame();
        logic [7:0] w;
        logic       exp_line, exp_fa;
        logic [1:0] exp_gr;
        logic [5:0] exp_bc;
        w = 8'hA5;
        do_reset();
        @(negedge clk);
        bus8.Req_Valid_In = 2'b01;
        bus8.Req_Data0_In = w;
        #1;
        checks++; if (bus8.Req_Ready_Out !== 2'b01) begin errors++; $display("FAIL single_ready got %b exp 01", bus8.Req_Ready_Out); end
        @(negedge clk);
        bus8.Req_Valid_In = 2'b00;
        for (int i = 0; i < 12; i++) begin
            exp_line = (i == 0) ? 1'b0 : ((i <= 8) ? w[i-1] : 1'b1);
            exp_fa   = (i < 10);
            exp_gr   = (i < 10) ? 2'b01 : 2'b00;
            exp_bc   = (i >= 1 && i <= 8) ? 6'(i - 1) : 6'd0;
            checks++; if (a_ser !== exp_line) begin errors++; $display("FAIL single_line[%0d] got %b exp %b", i, a_ser, exp_line); end
            checks++; if (a_fa !== exp_fa) begin errors++; $display("FAIL single_active[%0d] got %b exp %b", i, a_fa, exp_fa); end
            checks++; if (a_grant !== exp_gr) begin errors++; $display("FAIL single_grant[%0d] got %b exp %b", i, a_grant, exp_gr); end
            checks++; if (a_bc !== exp_bc) begin errors++; $display("FAIL single_bitcount[%0d] got %0d exp %0d", i, a_bc, exp_bc); end
            @(negedge clk);
        end
        $display("test_single_frame done");
    endtask

    task automatic test_round_robin();
        logic [1:0] ready_log [0:55];
        logic       line_log  [0:55];
        logic [1:0] exp_rdy;
        logic       exp_bit;
        do_reset();
        @(negedge clk);
        bus8.Req_Valid_In = 2'b11;
        bus8.Req_Data0_In = 8'h00;
        bus8.Req_Data1_In = 8'hFF;
        #1;
        for (int c = 0; c < 56; c++) begin
            ready_log[c] = bus8.Req_Ready_Out;
            line_log[c]  = a_ser;
            @(negedge clk);
        end
        bus8.Req_Valid_In = 2'b00;
        for (int f = 0; f < 4; f++) begin
            exp_rdy = (f % 2 == 1) ? 2'b10 : 2'b01;
            exp_bit = (f % 2 == 1);
            checks++; if (ready_log[13*f] !== exp_rdy) begin errors++; $display("FAIL rr_handshake[%0d] got %b exp %b", f, ready_log[13*f], exp_rdy); end
            checks++; if (ready_log[13*f+12] !== 2'b00) begin errors++; $display("FAIL rr_gap_ready[%0d] got %b exp 00", f, ready_log[13*f+12]); end
            checks++; if (line_log[13*f+1] !== 1'b0) begin errors++; $display("FAIL rr_start[%0d] got %b exp 0", f, line_log[13*f+1]); end
            for (int b = 0; b < 8; b++) begin
                checks++; if (line_log[13*f+2+b] !== exp_bit) begin errors++; $display("FAIL rr_data[%0d][%0d] got %b exp %b", f, b, line_log[13*f+2+b], exp_bit); end
            end
            checks++; if (line_log[13*f+10] !== 1'b1) begin errors++; $display("FAIL rr_stop[%0d] got %b exp 1", f, line_log[13*f+10]); end
        end
        $display("test_round_robin done");
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] w;
        logic       exp_line;
        w = 8'h96;
        do_reset();
        @(negedge clk);
        bus8.Req_Valid_In = 2'b01;
        bus8.Req_Data0_In = 8'h3C;
        @(negedge clk);
        bus8.Req_Valid_In = 2'b00;
        repeat (4) @(negedge clk);
        checks++; if (a_bc !== 6'd3) begin errors++; $display("FAIL abort_bitcount_before got %0d exp 3", a_bc); end
        checks++; if (a_ser !== 1'b1) begin errors++; $display("FAIL abort_bit3 got %b exp 1", a_ser); end
        Reset_In = 1'b1;
        #1;
        checks++; if (a_ser !== 1'b1) begin errors++; $display("FAIL abort_line got %b exp 1", a_ser); end
        checks++; if (a_fa !== 1'b0) begin errors++; $display("FAIL abort_active got %b exp 0", a_fa); end
        checks++; if (a_grant !== 2'b00) begin errors++; $display("FAIL abort_grant got %b exp 00", a_grant); end
        checks++; if (a_bc !== 6'd0) begin errors++; $display("FAIL abort_bitcount got %0d exp 0", a_bc); end
        @(negedge clk);
        Reset_In = 1'b0;
        bus8.Req_Valid_In = 2'b10;
        bus8.Req_Data1_In = w;
        #1;
        checks++; if (bus8.Req_Ready_Out !== 2'b10) begin errors++; $display("FAIL abort_new_ready got %b exp 10", bus8.Req_Ready_Out); end
        @(negedge clk);
        bus8.Req_Valid_In = 2'b00;
        for (int i = 0; i < 10; i++) begin
            exp_line = (i == 0) ? 1'b0 : ((i <= 8) ? w[i-1] : 1'b1);
            checks++; if (a_ser !== exp_line) begin errors++; $display("FAIL abort_new_line[%0d] got %b exp %b", i, a_ser, exp_line); end
            checks++; if (a_grant !== 2'b10) begin errors++; $display("FAIL abort_new_grant[%0d] got %b exp 10", i, a_grant); end
            @(negedge clk);
        end
        $display("test_reset_mid_frame done");
    endtask

    task automatic test_gap_request();
        do_reset();
        @(negedge clk);
        bus8.Req_Valid_In = 2'b01;
        bus8.Req_Data0_In = 8'h5A;
        @(negedge clk);
        bus8.Req_Valid_In = 2'b00;
        repeat (10) @(negedge clk);
        bus8.Req_Valid_In = 2'b01;
        bus8.Req_Data0_In = 8'h77;
        #1;
        checks++; if (a_fa !== 1'b0 || a_ser !== 1'b1) begin errors++; $display("FAIL gap_line got fa=%b line=%b exp fa=0 line=1", a_fa, a_ser); end
        checks++; if (bus8.Req_Ready_Out !== 2'b00) begin errors++; $display("FAIL gap_ready0 got %b exp 00", bus8.Req_Ready_Out); end
        @(negedge clk);
        checks++; if (bus8.Req_Ready_Out !== 2'b00) begin errors++; $display("FAIL gap_ready1 got %b exp 00", bus8.Req_Ready_Out); end
        @(negedge clk);
        checks++; if (bus8.Req_Ready_Out !== 2'b01) begin errors++; $display("FAIL gap_idle_ready got %b exp 01", bus8.Req_Ready_Out); end
        @(negedge clk);
        bus8.Req_Valid_In = 2'b00;
        checks++; if (a_ser !== 1'b0 || a_fa !== 1'b1 || a_grant !== 2'b01) begin errors++; $display("FAIL gap_next_start got line=%b fa=%b gr=%b exp 0 1 01", a_ser, a_fa, a_grant); end
        repeat (13) @(negedge clk);
        $display("test_gap_request done");
    endtask

    task automatic test_data_change();
        logic [7:0] w;
        w = 8'h11;
        do_reset();
        @(negedge clk);
        bus8.Req_Valid_In = 2'b01;
        bus8.Req_Data0_In = w;
        @(negedge clk);
        bus8.Req_Valid_In = 2'b00;
        bus8.Req_Data0_In = 8'h22;
        checks++; if (a_ser !== 1'b0) begin errors++; $display("FAIL change_start got %b exp 0", a_ser); end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++; if (a_ser !== w[i]) begin errors++; $display("FAIL change_data[%0d] got %b exp %b", i, a_ser, w[i]); end
        end
        $display("test_data_change done");
    endtask

    task automatic test_narrow();
        logic [1:0] ready_log [0:17];
        logic       line_log  [0:17];
        logic [5:0] bc_log    [0:17];
        logic [6:0] exp_seq;
        exp_seq = 7'b1100110;  // bit k = line value in cycle k+1: 0,1,1,0,0,1,1
        do_reset();
        @(negedge clk);
        bus5.Req_Valid_In = 2'b01;
        bus5.Req_Data0_In = 5'h13;
        bus5.Req_Data1_In = 5'h00;
        #1;
        for (int c = 0; c < 18; c++) begin
            ready_log[c] = bus5.Req_Ready_Out;
            line_log[c]  = b_ser;
            bc_log[c]    = b_bc;
            @(negedge clk);
        end
        bus5.Req_Valid_In = 2'b00;
        checks++; if (ready_log[0] !== 2'b01) begin errors++; $display("FAIL narrow_hs0 got %b exp 01", ready_log[0]); end
        checks++; if (ready_log[7] !== 2'b00) begin errors++; $display("FAIL narrow_stop_ready got %b exp 00", ready_log[7]); end
        checks++; if (ready_log[8] !== 2'b01) begin errors++; $display("FAIL narrow_hs1 got %b exp 01", ready_log[8]); end
        for (int k = 0; k < 7; k++) begin
            checks++; if (line_log[k+1] !== exp_seq[k]) begin errors++; $display("FAIL narrow_line[%0d] got %b exp %b", k, line_log[k+1], exp_seq[k]); end
        end
        for (int k = 0; k < 5; k++) begin
            checks++; if (bc_log[k+2] !== 6'(k)) begin errors++; $display("FAIL narrow_bitcount[%0d] got %0d exp %0d", k, bc_log[k+2], k); end
        end
        checks++; if (line_log[8] !== 1'b1) begin errors++; $display("FAIL narrow_idle_line got %b exp 1", line_log[8]); end
        checks++; if (line_log[9] !== 1'b0) begin errors++; $display("FAIL narrow_next_start got %b exp 0", line_log[9]); end
        $display("test_narrow done");
    endtask

    initial begin
        bus8.Req_Valid_In = 2'b00;
        bus8.Req_Data0_In = 8'h00;
        bus8.Req_Data1_In = 8'h00;
        bus5.Req_Valid_In = 2'b00;
        bus5.Req_Data0_In = 5'h00;
        bus5.Req_Data1_In = 5'h00;
        #2;
        test_reset();
        test_single_frame();
        test_round_robin();
        test_reset_mid_frame();
        test_gap_request();
        test_data_change();
        test_narrow();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
